rgb_pwm_driver: RTL and testbench

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

---
 rtl/rgb_pwm_driver_pkg.sv | 19 +
 rtl/rgb_pwm_driver_if.sv | 13 +
 rtl/rgb_pwm_driver_pwm_channel.sv | 28 ++
 rtl/rgb_pwm_driver.sv | 72 +++++++
 tb/tb_rgb_pwm_driver.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants and types for the RGB PWM driver: duty width, colour
// field offsets and the default prescale.
package rgb_pwm_driver_pkg;

  localparam int PWM_WIDTH        = 8;
  localparam int RGB_WIDTH        = 3 * PWM_WIDTH;
  localparam int R_LSB            = 16;
  localparam int G_LSB            = 8;
  localparam int B_LSB            = 0;
  localparam int PRESCALE_DEFAULT = 4;

  typedef logic [PWM_WIDTH-1:0] duty_t;
  typedef logic [RGB_WIDTH-1:0] rgb_t;

  function automatic duty_t colour_field(input rgb_t colour, input int lsb);
    return colour[lsb +: PWM_WIDTH];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour load handshake: the converter (master) offers rgb with rgb_valid,
// the driver (slave) takes it when rgb_ready is high.
interface rgb_pwm_driver_if;
  import rgb_pwm_driver_pkg::*;

  rgb_t rgb;
  logic rgb_valid;
  logic rgb_ready;

  modport master (output rgb, output rgb_valid, input rgb_ready);
  modport slave  (input rgb, input rgb_valid, output rgb_ready);

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: active duty register loaded at period wrap, and a
// registered compare against the shared step counter.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  logic  load,
  input  duty_t load_duty,
  input  duty_t cnt,
  output logic  led
);

  duty_t duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      if (load) duty <= load_duty;
      // compare uses the duty in force during this step, not the one being loaded
      led <= enable && (cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver: prescaler, 8-bit step counter and a single
// pending colour slot that is transferred to the channels at period wrap.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  rgb_pwm_driver_if.slave  col,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             period_start
);

  localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  duty_t       cnt;
  rgb_t        pend;
  logic        pend_full;
  logic        tick;
  logic        wrap;
  logic        accept;
  logic        load;

  assign tick          = enable && (pcnt == PCNT_LAST);
  assign wrap          = tick && (cnt == '1);
  assign accept        = col.rgb_valid && !pend_full;
  assign load          = wrap && pend_full;
  assign col.rgb_ready = !pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt         <= '0;
      cnt          <= '0;
      pend         <= '0;
      pend_full    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (tick)        pcnt <= '0;
      else if (enable) pcnt <= pcnt + 16'd1;
      if (tick) cnt <= cnt + 8'd1;
      // a colour taken on the wrap cycle stays pending until the next wrap
      if (load) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend      <= col.rgb;
        pend_full <= 1'b1;
      end
      period_start <= wrap;
    end
  end

  pwm_channel u_ch_r (
    .clk, .rst, .enable, .load,
    .load_duty(colour_field(pend, R_LSB)), .cnt, .led(led_r)
  );

  pwm_channel u_ch_g (
    .clk, .rst, .enable, .load,
    .load_duty(colour_field(pend, G_LSB)), .cnt, .led(led_g)
  );

  pwm_channel u_ch_b (
    .clk, .rst, .enable, .load,
    .load_duty(colour_field(pend, B_LSB)), .cnt, .led(led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: PRESCALE=1 and PRESCALE=4 instances share one
// stimulus stream and are compared every cycle against a period-count model.
module tb_rgb_pwm_driver;
  import rgb_pwm_driver_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rgb_valid;
  logic [23:0] rgb;

  logic led_r0, led_g0, led_b0, ps0;
  logic led_r1, led_g1, led_b1, ps1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver_if bus0 ();
  rgb_pwm_driver_if bus1 ();

  assign bus0.rgb       = rgb;
  assign bus0.rgb_valid = rgb_valid;
  assign bus1.rgb       = rgb;
  assign bus1.rgb_valid = rgb_valid;

  rgb_pwm_driver #(.PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .col(bus0),
    .led_r(led_r0), .led_g(led_g0), .led_b(led_b0), .period_start(ps0)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .col(bus1),
    .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_start(ps1)
  );

  // Reference model: n_m counts enabled cycles within one period of
  // 256*PRESCALE cycles; the step index is n_m / PRESCALE.
  int          pres [2] = '{1, 4};
  int          n_m  [2];
  int          duty_m [2][3];
  logic        pend_v [2];
  logic [23:0] pend_val [2];
  logic [4:0]  exp_v [2];
  int          lsbs [3] = '{R_LSB, G_LSB, B_LSB};

  // LED high-sample counts per completed period, per instance and channel
  int acc  [2][3];
  int hist [2][3];
  int ps_count;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [23:0] c);
    logic [2:0] obs_l [2];
    logic       obs_ps [2];
    rst = r; enable = e; rgb_valid = v; rgb = c;
    for (int i = 0; i < 2; i++) begin
      int         len, stp;
      logic       w, took;
      logic [2:0] lb;
      len = 256 * pres[i];
      stp = n_m[i] / pres[i];
      if (r) begin
        n_m[i] = 0;
        for (int k = 0; k < 3; k++) duty_m[i][k] = 0;
        pend_v[i]   = 1'b0;
        pend_val[i] = '0;
        exp_v[i]    = 5'b00001;
      end else begin
        w    = e && (((n_m[i] + 1) % len) == 0);
        took = v && !pend_v[i];
        for (int k = 0; k < 3; k++) lb[2-k] = e && (stp < duty_m[i][k]);
        if (w && pend_v[i]) begin
          for (int k = 0; k < 3; k++) duty_m[i][k] = int'(pend_val[i][lsbs[k] +: 8]);
          pend_v[i] = 1'b0;
        end
        if (took) begin
          pend_v[i]   = 1'b1;
          pend_val[i] = c;
        end
        if (e) n_m[i] = (n_m[i] + 1) % len;
        exp_v[i] = {lb, w, !pend_v[i]};
      end
    end
    @(posedge clk); #1;
    check_val("out_p1", {led_r0, led_g0, led_b0, ps0, bus0.rgb_ready}, exp_v[0]);
    check_val("out_p4", {led_r1, led_g1, led_b1, ps1, bus1.rgb_ready}, exp_v[1]);
    obs_l[0] = {led_r0, led_g0, led_b0}; obs_ps[0] = ps0;
    obs_l[1] = {led_r1, led_g1, led_b1}; obs_ps[1] = ps1;
    if (ps0) ps_count++;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) acc[i][k] += int'(obs_l[i][2-k]);
      if (obs_ps[i]) begin
        for (int k = 0; k < 3; k++) begin
          hist[i][k] = acc[i][k];
          acc[i][k]  = 0;
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int j = 0; j < cycles; j++) step(1'b0, 1'b1, 1'b0, 24'h0);
  endtask

  // hold valid until both instances have had a chance to take the colour
  task automatic send(input logic [23:0] c);
    int   k;
    logic rdy;
    k = 0;
    do begin
      rdy = bus1.rgb_ready;
      step(1'b0, 1'b1, 1'b1, c);
      k++;
    end while (!rdy && k < 2000);
    if (!rdy) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0; rgb_valid = 1'b0; rgb = '0;
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    check_val("rst_ready", 32'(bus0.rgb_ready), 32'd1);

    // full red, no green, half blue
    ps_count = 0;
    step(1'b0, 1'b1, 1'b1, 24'hFF0080);
    run(519);
    check_val("p1_ps_count", 32'(ps_count), 32'd2);
    check_val("p1_r_high", 32'(hist[0][0]), 32'd255);
    check_val("p1_g_high", 32'(hist[0][1]), 32'd0);
    check_val("p1_b_high", 32'(hist[0][2]), 32'd128);

    // back-pressure: second colour waits for a wrap
    send(24'h101010);
    send(24'h202020);
    run(600);
    check_val("bp_r_high", 32'(hist[0][0]), 32'd32);

    // pause at step 100 for 50 cycles, then resume
    k = 0;
    while (n_m[0] != 100 && k < 400) begin
      step(1'b0, 1'b1, 1'b0, 24'h0);
      k++;
    end
    for (int j = 0; j < 50; j++) step(1'b0, 1'b0, 1'b0, 24'h0);
    k = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, 24'h0);
      k++;
    end while (!ps0 && k < 400);
    check_val("resume_len", 32'(k), 32'd156);

    // reset mid-period with 0x80 duties
    send(24'h808080);
    run(1100);
    while (n_m[0] != 128) step(1'b0, 1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b1, 24'h123456);
    check_val("rst_mid", 32'({led_r0, led_g0, led_b0, ps0, bus0.rgb_ready}), 32'h1);
    run(300);

    // PRESCALE=4 with duty_r=2
    send(24'h020000);
    run(2200);
    check_val("p4_r_high", 32'(hist[1][0]), 32'd8);

    for (int j = 0; j < 4000; j++)
      step(($urandom % 500) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0, 24'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
